// File: rtl/shift_operations_if.sv
// Operand/result bundle for shift_operations.
// Optional carry_out/overflow flags exist only when SHIFT_FLAGS_EN is defined.
interface shift_operations_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned OP_W = 3;

  logic             in_valid;
  logic [WIDTH-1:0] data_in;
  logic [OP_W-1:0]  opcode;
  logic [WIDTH-1:0] result;
  logic             out_valid;
`ifdef SHIFT_FLAGS_EN
  logic             carry_out;
  logic             overflow;
`endif

  // Producer side: presents operands, observes results
  modport master (
    output in_valid, data_in, opcode,
`ifdef SHIFT_FLAGS_EN
    input  carry_out, overflow,
`endif
    input  result, out_valid
  );

  // Shift unit side
  modport slave (
    input  in_valid, data_in, opcode,
`ifdef SHIFT_FLAGS_EN
    output carry_out, overflow,
`endif
    output result, out_valid
  );
endinterface

// File: rtl/shift_operations.sv
// Registered fixed-distance shift/rotate unit, one-cycle latency.
// Optional macro SHIFT_FLAGS_EN adds registered carry_out/overflow flags.
module shift_operations #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  shift_operations_if.slave  bus
);
  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_PASS = 3'b000,
    OP_SLL1 = 3'b001,
    OP_SRL2 = 3'b010,
    OP_SLA3 = 3'b011,
    OP_SRA4 = 3'b100,
    OP_ROL5 = 3'b101,
    OP_ROR6 = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  logic [WIDTH-1:0] next_result;
  logic             msb;

  assign msb = bus.data_in[WIDTH-1];

  // Select the shifted operand; shifts are written as slices so every distance is fixed
  always_comb begin
    next_result = '0;
    case (op_e'(bus.opcode))
      OP_PASS: next_result = bus.data_in;
      OP_SLL1: next_result = {bus.data_in[WIDTH-2:0], 1'b0};
      OP_SRL2: next_result = {2'b00, bus.data_in[WIDTH-1:2]};
      OP_SLA3: next_result = {bus.data_in[WIDTH-4:0], 3'b000};
      OP_SRA4: next_result = {{4{msb}}, bus.data_in[WIDTH-1:4]};
      OP_ROL5: next_result = {bus.data_in[WIDTH-6:0], bus.data_in[WIDTH-1:WIDTH-5]};
      OP_ROR6: next_result = {bus.data_in[5:0], bus.data_in[WIDTH-1:6]};
      OP_RSVD: next_result = '0;
      default: next_result = '0;
    endcase
  end

  // Result register: reset clears, idle cycles hold the last result
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result    <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.result <= next_result;
      end
    end
  end

`ifdef SHIFT_FLAGS_EN
  logic next_carry;
  logic next_overflow;

  // Carry is the last bit shifted out (or wrapped round, for rotates)
  always_comb begin
    next_carry    = 1'b0;
    next_overflow = 1'b0;
    case (op_e'(bus.opcode))
      OP_SLL1: next_carry = bus.data_in[WIDTH-1];
      OP_SRL2: next_carry = bus.data_in[1];
      OP_SLA3: begin
        next_carry    = bus.data_in[WIDTH-3];
        // Top four bits must agree or the x8 result no longer fits in signed WIDTH bits
        next_overflow = !((bus.data_in[WIDTH-1:WIDTH-4] == 4'b0000) ||
                          (bus.data_in[WIDTH-1:WIDTH-4] == 4'b1111));
      end
      OP_SRA4: next_carry = bus.data_in[3];
      OP_ROL5: next_carry = next_result[0];
      OP_ROR6: next_carry = next_result[WIDTH-1];
      default: begin
        next_carry    = 1'b0;
        next_overflow = 1'b0;
      end
    endcase
  end

  // Flag registers track the result register timing
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.carry_out <= 1'b0;
      bus.overflow  <= 1'b0;
    end else if (bus.in_valid) begin
      bus.carry_out <= next_carry;
      bus.overflow  <= next_overflow;
    end
  end
`endif

endmodule

// File: tb/tb_shift_operations.sv
// Self-checking bench for shift_operations (WIDTH=8), with optional SHIFT_FLAGS_EN checks.
module tb_shift_operations;
  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_result;
  logic             exp_valid;
  logic             exp_carry;
  logic             exp_ovf;

  shift_operations_if #(.WIDTH(WIDTH)) bus ();

  shift_operations #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference result from arithmetic on the operand value
  function automatic logic [7:0] model_result(input logic [7:0] d, input logic [2:0] op);
    int v;
    int s;
    logic [7:0] r;
    v = int'(d);
    r = 8'h00;
    case (op)
      3'd0: r = d;
      3'd1: r = 8'((v * 2) % 256);
      3'd2: r = 8'(v / 4);
      3'd3: r = 8'((v * 8) % 256);
      3'd4: begin
        s = d[7] ? v - 256 : v;
        r = 8'(s >>> 4);
      end
      3'd5: for (int i = 0; i < 8; i++) r[(i + 5) % 8] = d[i];
      3'd6: for (int i = 0; i < 8; i++) r[(i + 2) % 8] = d[i];
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Reference carry: bit that falls off the end, or wraps for rotates
  function automatic logic model_carry(input logic [7:0] d, input logic [2:0] op);
    int v;
    logic [7:0] r;
    v = int'(d);
    r = model_result(d, op);
    case (op)
      3'd1: return ((v * 2) / 256) % 2 == 1;
      3'd2: return (v % 4) / 2 == 1;
      3'd3: return ((v * 8) / 256) % 2 == 1;
      3'd4: return (v % 16) / 8 == 1;
      3'd5: return r[0];
      3'd6: return r[7];
      default: return 1'b0;
    endcase
  endfunction

  // Reference overflow: signed x8 leaves the signed 8-bit range
  function automatic logic model_ovf(input logic [7:0] d, input logic [2:0] op);
    int s;
    s = d[7] ? int'(d) - 256 : int'(d);
    if (op != 3'd3) return 1'b0;
    return (s * 8 > 127) || (s * 8 < -128);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance past the edge, update the scoreboard and compare
  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic [2:0] op);
    rst          = r;
    bus.in_valid = v;
    bus.data_in  = d;
    bus.opcode   = op;
    @(posedge clk);
    #1;
    if (r) begin
      exp_result = '0;
      exp_valid  = 1'b0;
      exp_carry  = 1'b0;
      exp_ovf    = 1'b0;
    end else if (v) begin
      exp_result = model_result(d, op);
      exp_valid  = 1'b1;
      exp_carry  = model_carry(d, op);
      exp_ovf    = model_ovf(d, op);
    end else begin
      exp_valid  = 1'b0;
    end
    check("result", 32'(bus.result), 32'(exp_result));
    check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
`ifdef SHIFT_FLAGS_EN
    check("carry_out", 32'(bus.carry_out), 32'(exp_carry));
    check("overflow", 32'(bus.overflow), 32'(exp_ovf));
`endif
  endtask

  logic [7:0] plan_cc [7];
  logic [7:0] rd;
  logic [2:0] rop;

  initial begin
    plan_cc[0] = 8'hCC; plan_cc[1] = 8'h98; plan_cc[2] = 8'h33; plan_cc[3] = 8'h60;
    plan_cc[4] = 8'hFC; plan_cc[5] = 8'h99; plan_cc[6] = 8'h33;
    exp_result = '0;
    exp_valid  = 1'b0;
    exp_carry  = 1'b0;
    exp_ovf    = 1'b0;

    // Reset held two cycles with a live operand present
    step(1'b1, 1'b1, 8'hCC, 3'd0);
    step(1'b1, 1'b1, 8'hCC, 3'd0);
    check("reset_result", 32'(bus.result), 32'h0);

    // Walk 0xCC through opcodes 000..110
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 8'hCC, 3'(i));
      check("plan_cc", 32'(bus.result), 32'(plan_cc[i]));
`ifdef SHIFT_FLAGS_EN
      if (i == 1) check("plan_c001", 32'(bus.carry_out), 32'd1);
      if (i == 3) begin
        check("plan_c011", 32'(bus.carry_out), 32'd0);
        check("plan_v011", 32'(bus.overflow), 32'd1);
      end
      if (i == 4) check("plan_c100", 32'(bus.carry_out), 32'd1);
      if (i == 5) check("plan_c101", 32'(bus.carry_out), 32'd1);
      if (i == 6) check("plan_c110", 32'(bus.carry_out), 32'd0);
`endif
    end

    // Reserved opcode, then idle cycles hold the result
    step(1'b0, 1'b1, 8'hCC, 3'd7);
    check("plan_rsvd", 32'(bus.result), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'hA5, 3'd1);
    check("idle_hold", 32'(bus.result), 32'h0);

    // Sign-fill and zero-fill boundaries
    step(1'b0, 1'b1, 8'h7F, 3'd4);
    check("sra_pos", 32'(bus.result), 32'h07);
    step(1'b0, 1'b1, 8'h80, 3'd4);
    check("sra_neg", 32'(bus.result), 32'hF8);
    step(1'b0, 1'b1, 8'hFF, 3'd2);
    check("srl_ones", 32'(bus.result), 32'h3F);
    step(1'b0, 1'b1, 8'hFF, 3'd4);
    check("sra_ones", 32'(bus.result), 32'hFF);
    step(1'b0, 1'b1, 8'h03, 3'd3);
`ifdef SHIFT_FLAGS_EN
    check("plan_v03", 32'(bus.overflow), 32'd0);
`endif
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 3'(i));

    // Hold after a nonzero result, then reset mid-stream drops the operand
    step(1'b0, 1'b1, 8'h5A, 3'd5);
    step(1'b0, 1'b0, 8'h00, 3'd0);
    check("hold_nz", 32'(bus.result), 32'(model_result(8'h5A, 3'd5)));
    step(1'b1, 1'b1, 8'hFF, 3'd0);
    check("mid_reset", 32'(bus.result), 32'h0);

    // Back-to-back random traffic
    for (int i = 0; i < 300; i++) begin
      rd  = 8'($urandom);
      rop = 3'($urandom_range(0, 7));
      step(1'b0, 1'b1, rd, rop);
      if (rop == 3'd5 || rop == 3'd6)
        check("rot_popcount", 32'($countones(bus.result)), 32'($countones(rd)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_operations.md
Name: shift_operations

Overview:
- Registered 8-bit (parameterisable) shift/rotate unit.
- A 3-bit opcode selects one of seven fixed-distance operations: pass-through, logical, algebraic (arithmetic) or rotate.
- Sits as a small datapath helper beside the ALU. One operand is accepted per cycle when in_valid is high; the result appears one clock later with out_valid.

Parameters:
- WIDTH, 8, data width in bits. Must be >= 8 so that every fixed shift distance (max 6) is smaller than WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  data_in/opcode are valid this cycle.
- data_in  input  WIDTH  operand.
- opcode  input  3  operation select.
- result  output  WIDTH  registered operation result.
- out_valid  output  1  result was updated on the last edge.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: on a rising clk with rst=1, result <= 0 and out_valid <= 0. rst has priority over in_valid.
- Latency: exactly 1 cycle. When in_valid=1 at edge N, result = f(data_in, opcode) and out_valid=1 after edge N.
- When in_valid=0: result holds its previous value and out_valid <= 0.
- No backpressure; a new operand may be accepted every cycle.
- Opcode map. Shift distances are fixed and independent of WIDTH. "msb" means data_in[WIDTH-1].
  - 000 pass: result = data_in.
  - 001 logical shift left by 1, zero fill.
  - 010 logical shift right by 2, zero fill.
  - 011 algebraic shift left by 3, zero fill into the LSBs. Bit pattern is identical to a logical left shift.
  - 100 algebraic shift right by 4, vacated MSBs filled with msb (sign extension).
  - 101 rotate left by 5: result = (data_in << 5) | (data_in >> (WIDTH-5)).
  - 110 rotate right by 6: result = (data_in >> 6) | (data_in << (WIDTH-6)).
  - 111 reserved: result = 0.
- Purely combinational next-state function; no internal state besides the output registers.
- Boundary cases:
  - All-zero input gives 0 for every opcode.
  - All-ones input: 100 gives all-ones; 001/010/011 shift zeros in.
  - Rotates never lose bits, so the population count is preserved.
- Reset asserted mid-stream discards any operand presented in that same cycle.

Optional Feature:
- Macro: SHIFT_FLAGS_EN.
- With the macro defined, add registered outputs carry_out (1) and overflow (1). They have the same latency and reset value (0) as result, and hold when in_valid=0.
- carry_out is defined per opcode:
  - 001: last bit shifted out, data_in[WIDTH-1].
  - 010: data_in[1].
  - 011: data_in[WIDTH-3].
  - 100: data_in[3].
  - 101: result[0].
  - 110: result[WIDTH-1].
  - 000 and 111: 0.
- overflow = 1 only for opcode 011 when data_in[WIDTH-1:WIDTH-4] are not all equal, i.e. the sign changed or significant bits were lost. overflow = 0 for every other opcode.
- Without the macro, these ports and their logic do not exist.

Test Plan:
- Hold rst=1 for 2 cycles with in_valid=1 and data_in=0xCC -> result=0x00, out_valid=0. Release rst -> first valid result one cycle later.
- data_in=0xCC with in_valid=1, stepping opcode 000..110 one per cycle -> results one cycle later: 0xCC, 0x98, 0x33, 0x60, 0xFC, 0x99, 0x33.
- data_in=0xCC, opcode=111 -> result=0x00. Then in_valid=0 for 3 cycles -> result holds 0x00 and out_valid=0.
- data_in=0x7F, opcode=100 -> 0x07. data_in=0x80, opcode=100 -> 0xF8. data_in=0xFF, opcode=010 -> 0x3F.
- Back-to-back in_valid every cycle with random data/opcodes -> out_valid stays 1 and each result matches the software model of the previous cycle's inputs.
- With SHIFT_FLAGS_EN and data_in=0xCC:
  - 001 -> carry_out=1.
  - 011 -> carry_out=0, overflow=1.
  - 100 -> carry_out=1.
  - 101 -> carry_out=1.
  - 110 -> carry_out=0.
  - data_in=0x03, opcode=011 -> overflow=0.
